// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared encodings and constants for the instruction-fetch stage
package if_stage_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } if_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// rtl/if_stage_if_id_reg.sv - IF/ID boundary register with load, bubble and flush plus field slicing
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        flush,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_pc4,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16,
  output logic [25:0] id_imm26
);

  // Flush wins over load so a redirect always leaves a clean NOP behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid <= 1'b0;
      id_instr <= NOP_WORD;
      id_pc4   <= 32'h0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= NOP_WORD;
    end else if (load) begin
      id_valid <= 1'b1;
      id_instr <= ld_instr;
      id_pc4   <= ld_pc4;
    end else if (bubble) begin
      id_valid <= 1'b0;
    end
  end

  assign id_opcode = id_instr[31:26];
  assign id_rs     = id_instr[25:21];
  assign id_rt     = id_instr[20:16];
  assign id_rd     = id_instr[15:11];
  assign id_shamt  = id_instr[10:6];
  assign id_funct  = id_instr[5:0];
  assign id_imm16  = id_instr[15:0];
  assign id_imm26  = id_instr[25:0];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, fetch handshake, stall buffer, IF/ID register
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16,
  output logic [25:0] id_imm26
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc4;
  logic [31:0] pc_plus4;
  logic        fetch_done;
  logic        load;
  logic        bubble;
  logic [31:0] ld_instr;
  logic [31:0] ld_pc4;

  assign pc_plus4   = pc + 32'd4;
  assign imem_addr  = pc;
  assign fetch_done = (state == FETCH) && imem_ready;

  // A parked word takes priority over memory; in HELD no request is outstanding.
  assign load     = !redirect_i && !stall_i && (fetch_done || (state == HELD));
  assign bubble   = !redirect_i && !stall_i && (state == FETCH) && !imem_ready;
  assign ld_instr = (state == HELD) ? buf_instr : imem_rdata;
  assign ld_pc4   = (state == HELD) ? buf_pc4 : pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      imem_req  <= 1'b1;
      pc        <= align_word(RESET_PC);
      buf_instr <= NOP_WORD;
      buf_pc4   <= 32'h0;
    end else if (redirect_i) begin
      state     <= FETCH;
      imem_req  <= 1'b1;
      pc        <= align_word(redirect_pc);
      buf_instr <= NOP_WORD;
      buf_pc4   <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_plus4;
            if (stall_i) begin
              buf_instr <= imem_rdata;
              buf_pc4   <= pc_plus4;
              state     <= HELD;
              imem_req  <= 1'b0;
            end
          end
        end
        HELD: begin
          if (!stall_i) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .bubble    (bubble),
    .flush     (redirect_i),
    .ld_instr  (ld_instr),
    .ld_pc4    (ld_pc4),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc4    (id_pc4),
    .id_opcode (id_opcode),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .id_shamt  (id_shamt),
    .id_funct  (id_funct),
    .id_imm16  (id_imm16),
    .id_imm26  (id_imm26)
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against a queue-based fetch model
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic [25:0] id_imm26;

  int total = 0;
  int bad   = 0;

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc4      (id_pc4),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_shamt    (id_shamt),
    .id_funct    (id_funct),
    .id_imm16    (id_imm16),
    .id_imm26    (id_imm26)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return {a[15:0], a[15:0] ^ 16'hBEEF};
  endfunction

  // Instruction memory answers with an address-derived word.
  assign imem_rdata = tag(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: program-order view with a pending-word queue between memory and decode.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_known;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [63:0] m_park[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc    = 32'h0000_3000;
      m_valid = 1'b0;
      m_known = 1'b1;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_park.delete();
    end else if (redirect_i) begin
      m_pc    = redirect_pc & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_known = 1'b1;
      m_instr = 32'h0;
      m_park.delete();
    end else if (m_park.size() > 0) begin
      if (!stall_i) begin
        {m_instr, m_pc4} = m_park.pop_front();
        m_valid = 1'b1;
        m_known = 1'b1;
      end
    end else if (imem_ready) begin
      if (stall_i) m_park.push_back({tag(m_pc), m_pc + 32'd4});
      else begin
        m_instr = tag(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_known = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall_i) begin
      m_valid = 1'b0;
      m_known = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_req",   {31'h0, imem_req}, {31'h0, m_park.size() == 0});
      chk("m_addr",  imem_addr, m_pc);
      chk("m_valid", {31'h0, id_valid}, {31'h0, m_valid});
      if (m_known) chk("m_instr", id_instr, m_instr);
      if (m_valid) begin
        chk("m_pc4",    id_pc4, m_pc4);
        chk("m_opcode", {26'h0, id_opcode}, {26'h0, m_instr[31:26]});
        chk("m_rs",     {27'h0, id_rs},     {27'h0, m_instr[25:21]});
        chk("m_rt",     {27'h0, id_rt},     {27'h0, m_instr[20:16]});
        chk("m_rd",     {27'h0, id_rd},     {27'h0, m_instr[15:11]});
        chk("m_shamt",  {27'h0, id_shamt},  {27'h0, m_instr[10:6]});
        chk("m_funct",  {26'h0, id_funct},  {26'h0, m_instr[5:0]});
        chk("m_imm16",  {16'h0, id_imm16},  {16'h0, m_instr[15:0]});
        chk("m_imm26",  {6'h0, id_imm26},   {6'h0, m_instr[25:0]});
      end
    end
  end

  task automatic cyc(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
    stall_i     = s;
    redirect_i  = r;
    redirect_pc = rpc;
    imem_ready  = rdy;
    @(posedge clk);
    #2;
  endtask

  typedef struct packed {
    logic        s;
    logic        r;
    logic [31:0] rpc;
    logic        rdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    #1;
    chk("rst_req",   {31'h0, imem_req}, 32'h1);
    chk("rst_addr",  imem_addr, 32'h0000_3000);
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc4",   id_pc4, 32'h0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    cyc(0, 0, 0, 1);
    chk("seq_pc4_0", id_pc4, 32'h0000_3004);
    chk("seq_val_0", {31'h0, id_valid}, 32'h1);
    chk("seq_ins_0", id_instr, 32'h3000_8EEF);
    cyc(0, 0, 0, 1);
    chk("seq_pc4_1", id_pc4, 32'h0000_3008);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      chk("wait_valid", {31'h0, id_valid}, 32'h0);
      chk("wait_addr", imem_addr, 32'h0000_3008);
    end
    cyc(0, 0, 0, 1);
    chk("wait_pc4", id_pc4, 32'h0000_300C);
    chk("wait_ins", id_instr, 32'h3008_8EE7);

    cyc(1, 0, 0, 1);
    chk("stall_pc4", id_pc4, 32'h0000_300C);
    chk("stall_req", {31'h0, imem_req}, 32'h0);
    cyc(1, 0, 0, 1);
    chk("stall2_pc4", id_pc4, 32'h0000_300C);
    chk("stall2_req", {31'h0, imem_req}, 32'h0);
    cyc(0, 0, 0, 1);
    chk("rel_pc4",  id_pc4, 32'h0000_3010);
    chk("rel_ins",  id_instr, 32'h300C_8EE3);
    chk("rel_req",  {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0000_3010);
    cyc(0, 0, 0, 1);
    chk("rel_next", id_pc4, 32'h0000_3014);

    cyc(1, 0, 0, 1);
    cyc(1, 1, 32'h0000_4003, 1);
    chk("redir_valid", {31'h0, id_valid}, 32'h0);
    chk("redir_instr", id_instr, 32'h0);
    chk("redir_addr",  imem_addr, 32'h0000_4000);
    chk("redir_req",   {31'h0, imem_req}, 32'h1);
    cyc(0, 0, 0, 1);
    chk("redir_pc4", id_pc4, 32'h0000_4004);

    cyc(0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("wrap_pc4",  id_pc4, 32'h0000_0000);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    cyc(1, 0, 0, 1);
    chk("held_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b1;
    #1;
    chk("arst_addr",  imem_addr, 32'h0000_3000);
    chk("arst_valid", {31'h0, id_valid}, 32'h0);
    chk("arst_instr", id_instr, 32'h0);
    chk("arst_req",   {31'h0, imem_req}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b0;

    tbl[0]  = '{0, 0, 32'h0, 1};  tbl[1]  = '{1, 0, 32'h0, 0};
    tbl[2]  = '{1, 0, 32'h0, 1};  tbl[3]  = '{0, 0, 32'h0, 0};
    tbl[4]  = '{0, 0, 32'h0, 1};  tbl[5]  = '{1, 0, 32'h0, 1};
    tbl[6]  = '{0, 0, 32'h0, 0};  tbl[7]  = '{0, 1, 32'h0000_0101, 0};
    tbl[8]  = '{0, 0, 32'h0, 1};  tbl[9]  = '{1, 0, 32'h0, 1};
    tbl[10] = '{1, 1, 32'h0000_2222, 0};  tbl[11] = '{0, 0, 32'h0, 1};
    tbl[12] = '{0, 0, 32'h0, 1};  tbl[13] = '{1, 0, 32'h0, 0};
    tbl[14] = '{0, 0, 32'h0, 1};  tbl[15] = '{0, 0, 32'h0, 1};
    for (int i = 0; i < 16; i++) cyc(tbl[i].s, tbl[i].r, tbl[i].rpc, tbl[i].rdy);
    cyc(0, 0, 0, 1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
